mips_cpu_mult_div: RTL and testbench
====================================

# mips_cpu_mult_div

Iterative multiply/divide unit owning the architectural HI/LO registers. Consumes the rs/rt operand pair produced by the register-file read ports and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Exposes HI/LO to the writeback path for MFHI/MFLO, which then writes them back into the register file. A busy flag lets the control unit stall any dependent instruction.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled on the rising edge of clk.
- op  in  3  operation code; encoding is in the shared package.
- operand_a  in  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- operand_b  in  32  rt value: multiplier or divisor.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse when new HI/LO results become visible.

## Operation
- **Reset values:** states IDLE, MUL, DIV. Reset gives state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- **Accepted start (state=IDLE and start=1):**
  - MTHI: hi<=operand_a.
  - MTLO: lo<=operand_a.
  - Both are single-edge, go to no other state and raise no done pulse.
  - MULT/MULTU go to MUL; DIV/DIVU go to DIV. The unit latches |a|, |b|, the sign flags and the op, and clears counter.
  - Signed ops take two's-complement magnitudes. Unsigned ops use the operands as-is.
  - Reserved op codes are ignored.
- **start while busy=1:** ignored, with no effect on state, hi or lo. The control unit must stall.
- **MUL:** shift-add, one multiplier bit per cycle, 64-bit accumulator.
- **DIV:** restoring division, one quotient bit per cycle, 33-bit partial remainder.
- **Iteration count:** counter counts 0..31. On the edge at counter=31 the unit applies sign fix-up, writes hi/lo, returns to IDLE and sets done=1 for one cycle.
- **Signed multiply:** the 64-bit product is negated if sign_a XOR sign_b. hi=product[63:32], lo=product[31:0].
- **Signed divide:**
  - Quotient truncates toward zero and is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- **Divide by zero (operand_b=0, both DIV and DIVU):** runs the full latency, then gives lo=32'hFFFF_FFFF and hi=original operand_a.
- **Signed overflow (0x8000_0000 / 0xFFFF_FFFF):** lo=32'h8000_0000, hi=0. This falls out of the magnitude path and needs no special case.
- **hi/lo stability:** hi/lo hold their old values throughout an iteration. They change only at completion, MTHI/MTLO, or reset.
- **Reset mid-operation:** aborts. Next cycle is IDLE with hi=lo=0, busy=0, and no done pulse.

## Timing
- **Start sampling:** start is sampled at edge E0.
- **busy:** busy=1 for exactly 32 cycles, from the cycle after E0 through the cycle after edge E31.
- **Completion:** at edge E32 hi/lo update and busy falls. done=1 during the cycle after E32 only.
- **Back-to-back ops:** a new start may be presented in the done cycle and is accepted, giving back-to-back ops every 33 cycles.
- **MTHI/MTLO latency:** new hi/lo are visible the cycle after the accepting edge.
- **Output registration:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Simultaneous reset and start:** reset wins.

## Structure
- **Shared package mips_cpu_pkg:**
  - op enum with OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5; codes 6–7 are reserved.
  - state enum (IDLE, MUL, DIV).
  - localparam ITERATIONS=32.
- **Sub-module:** mips_cpu_div_step, a combinational single restoring-division step. It takes a partial remainder, the divisor and the next dividend bit, and returns the new remainder and quotient bit. The top level keeps the FSM, counter, multiply datapath and HI/LO.

## Test plan
- **MULT 7 × -3:** expect busy for 32 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, and done for one cycle.
- **MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:** expect hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- **Signed divide cases:**
  - DIV -7 / 2: expect lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
  - DIVU 100 / 7: expect lo=14, hi=2.
- **Divide by zero:** DIV 0x1234 / 0 gives lo=32'hFFFF_FFFF, hi=32'h0000_1234. DIV 0x8000_0000 / -1 gives lo=32'h8000_0000, hi=0.
- **MTHI and ignored start:** MTHI 0xDEAD_BEEF gives hi=0xDEAD_BEEF next cycle with done=0. A start (MULTU 2×3) asserted during cycle 10 of a running DIVU is ignored; the DIVU result is unaffected.
- **Reset mid-operation:** assert reset at iteration 15 of a MULT. Next cycle busy=0, done=0, hi=lo=0. A new MULTU 5×6 then gives lo=30, hi=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared op/state encodings and helpers for the MIPS mult/div unit
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    localparam int ITERATIONS = 32;

    // Two's-complement magnitude for signed ops, pass-through for unsigned ones.
    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// rtl/mips_cpu_div_step.sv - one combinational restoring-division step
module mips_cpu_div_step (
    input  logic [32:0] i_rem,
    input  logic [31:0] i_divisor,
    input  logic        i_bit,
    output logic [32:0] o_rem,
    output logic        o_q
);

    logic [33:0] w_shift;

    assign w_shift = {i_rem, i_bit};
    assign o_q     = (w_shift >= {2'b00, i_divisor});
    assign o_rem   = o_q ? (w_shift[32:0] - {1'b0, i_divisor}) : w_shift[32:0];

endmodule

// File: rtl/mips_cpu_mult_div.sv
// rtl/mips_cpu_mult_div.sv - iterative 32-cycle multiply/divide unit owning HI/LO
module mips_cpu_mult_div
    import mips_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done
);

    state_e      r_state;
    logic [4:0]  r_counter;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_orig_a;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_div_zero;
    logic [63:0] r_acc;
    logic [32:0] r_rem;

    logic        w_signed_op;
    logic        w_is_mul;
    logic        w_neg;
    logic        w_last;
    logic [32:0] w_mul_sum;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;
    logic [32:0] w_rem_next;
    logic        w_q;
    logic [31:0] w_quot;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_neg       = r_sign_a ^ r_sign_b;
    assign w_last      = (r_counter == 5'(ITERATIONS - 1));

    // Multiplier sits in the low half of the accumulator and is consumed LSB-first.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_acc_next = {w_mul_sum, r_acc[31:1]};
    assign w_prod     = w_neg ? (~w_acc_next + 64'd1) : w_acc_next;

    // The dividend shifts out of r_a MSB-first while quotient bits shift in at the LSB.
    mips_cpu_div_step u_div_step (
        .i_rem     (r_rem),
        .i_divisor (r_b),
        .i_bit     (r_a[31]),
        .o_rem     (w_rem_next),
        .o_q       (w_q)
    );

    assign w_quot     = {r_a[30:0], w_q};
    assign w_quot_fix = w_neg ? (~w_quot + 32'd1) : w_quot;
    assign w_rem_fix  = r_sign_a ? (~w_rem_next[31:0] + 32'd1) : w_rem_next[31:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_counter  <= 5'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_orig_a   <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_rem      <= '0;
            o_hi       <= '0;
            o_lo       <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        case (i_op)
                            OP_MTHI: o_hi <= i_operand_a;
                            OP_MTLO: o_lo <= i_operand_a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_a        <= magnitude(i_operand_a, w_signed_op);
                                r_b        <= magnitude(i_operand_b, w_signed_op);
                                r_sign_a   <= w_signed_op & i_operand_a[31];
                                r_sign_b   <= w_signed_op & i_operand_b[31];
                                r_orig_a   <= i_operand_a;
                                r_div_zero <= (i_operand_b == 32'd0);
                                r_acc      <= {32'd0, magnitude(i_operand_b, w_signed_op)};
                                r_rem      <= '0;
                                r_counter  <= 5'd0;
                                o_busy     <= 1'b1;
                                r_state    <= w_is_mul ? MUL : DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    r_acc     <= w_acc_next;
                    r_counter <= r_counter + 5'd1;
                    if (w_last) begin
                        o_hi    <= w_prod[63:32];
                        o_lo    <= w_prod[31:0];
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    r_rem     <= w_rem_next;
                    r_a       <= w_quot;
                    r_counter <= r_counter + 5'd1;
                    if (w_last) begin
                        if (r_div_zero) begin
                            o_lo <= 32'hFFFF_FFFF;
                            o_hi <= r_orig_a;
                        end else begin
                            o_lo <= w_quot_fix;
                            o_hi <= w_rem_fix;
                        end
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
// tb/tb_mips_cpu_mult_div.sv - directed self-checking bench for mips_cpu_mult_div
module tb_mips_cpu_mult_div;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_cpu_mult_div #(.DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_op        (op),
        .i_operand_a (operand_a),
        .i_operand_b (operand_b),
        .o_hi        (hi),
        .o_lo        (lo),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Called at a negedge; returns at the negedge after completion (the done cycle).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output logic done_seen, output logic hold_ok);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        old_hi = hi; old_lo = lo;
        busy_cnt = 0; hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
        end
        done_seen = done;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (hi !== 32'd0)  begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'd0)  begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_mthi_mtlo;
        op = OP_MTHI; operand_a = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (hi !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mthi_hi: got %h want deadbeef", hi); end
        if (done !== 1'b0)        begin n_err++; $display("FAIL mthi_done: got %b want 0", done); end
        if (busy !== 1'b0)        begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end
        op = OP_MTLO; operand_a = 32'h0BAD_F00D; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (lo !== 32'h0BAD_F00D) begin n_err++; $display("FAIL mtlo_lo: got %h want 0badf00d", lo); end
        if (hi !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want deadbeef", hi); end
        // Reserved codes must not start anything or touch HI/LO.
        for (int c = 6; c < 8; c++) begin
            op = 3'(c); operand_a = 32'h1111_2222; operand_b = 32'd3; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            n_cmp += 3;
            if (busy !== 1'b0)        begin n_err++; $display("FAIL reserved_busy op%0d: got %b want 0", c, busy); end
            if (hi !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL reserved_hi op%0d: got %h want deadbeef", c, hi); end
            if (lo !== 32'h0BAD_F00D) begin n_err++; $display("FAIL reserved_lo op%0d: got %h want 0badf00d", c, lo); end
        end
    endtask

    task automatic test_mult;
        int bc; logic ds; logic hk;
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, bc, ds, hk);
        n_cmp += 5;
        if (bc !== 32)            begin n_err++; $display("FAIL mult_busy_cycles: got %0d want 32", bc); end
        if (ds !== 1'b1)          begin n_err++; $display("FAIL mult_done: got %b want 1", ds); end
        if (hk !== 1'b1)          begin n_err++; $display("FAIL mult_hold: hi/lo changed while busy"); end
        if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_multu;
        int bc; logic ds; logic hk;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, ds, hk);
        n_cmp += 3;
        if (ds !== 1'b1)          begin n_err++; $display("FAIL multu_done: got %b want 1", ds); end
        if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int bc; logic ds; logic hk;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, ds, hk);
        n_cmp += 3;
        if (bc !== 32)            begin n_err++; $display("FAIL div_busy_cycles: got %0d want 32", bc); end
        if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        @(negedge clk);
        run_op(OP_DIVU, 32'd100, 32'd7, bc, ds, hk);
        n_cmp += 2;
        if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        if (hi !== 32'd2)  begin n_err++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        @(negedge clk);
    endtask

    task automatic test_div_edge;
        int bc; logic ds; logic hk;
        run_op(OP_DIV, 32'h0000_1234, 32'd0, bc, ds, hk);
        n_cmp += 3;
        if (bc !== 32)            begin n_err++; $display("FAIL divzero_busy_cycles: got %0d want 32", bc); end
        if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divzero_lo: got %h want ffffffff", lo); end
        if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL divzero_hi: got %h want 00001234", hi); end
        @(negedge clk);
        run_op(OP_DIVU, 32'h8765_4321, 32'd0, bc, ds, hk);
        n_cmp += 2;
        if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divuzero_lo: got %h want ffffffff", lo); end
        if (hi !== 32'h8765_4321) begin n_err++; $display("FAIL divuzero_hi: got %h want 87654321", hi); end
        @(negedge clk);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, ds, hk);
        n_cmp += 2;
        if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        if (hi !== 32'd0)         begin n_err++; $display("FAIL divovf_hi: got %h want 0", hi); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start;
        int cnt;
        cnt = 0;
        op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd33; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) break;
            cnt++;
            if (cnt == 10) begin
                op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
            end
        end
        n_cmp += 4;
        if (cnt !== 32)     begin n_err++; $display("FAIL ignored_busy_cycles: got %0d want 32", cnt); end
        if (done !== 1'b1)  begin n_err++; $display("FAIL ignored_done: got %b want 1", done); end
        if (lo !== 32'd30)  begin n_err++; $display("FAIL ignored_lo: got %h want 0000001e", lo); end
        if (hi !== 32'd10)  begin n_err++; $display("FAIL ignored_hi: got %h want 0000000a", hi); end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ignored_no_restart: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int bc; logic ds; logic hk;
        run_op(OP_MULTU, 32'd3, 32'd4, bc, ds, hk);
        n_cmp++;
        if (lo !== 32'd12) begin n_err++; $display("FAIL b2b_first_lo: got %h want 0000000c", lo); end
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, bc, ds, hk);
        n_cmp += 5;
        if (bc !== 32)            begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 32", bc); end
        if (ds !== 1'b1)          begin n_err++; $display("FAIL b2b_done: got %b want 1", ds); end
        if (hk !== 1'b1)          begin n_err++; $display("FAIL b2b_hold: hi/lo changed while busy"); end
        if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL b2b_lo: got %h want fffffff2", lo); end
        if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_hi: got %h want fffffffe", hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bc; logic ds; logic hk;
        op = OP_MULT; operand_a = 32'd123; operand_b = 32'd456; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", done); end
        if (hi !== 32'd0)  begin n_err++; $display("FAIL midreset_hi: got %h want 0", hi); end
        if (lo !== 32'd0)  begin n_err++; $display("FAIL midreset_lo: got %h want 0", lo); end
        run_op(OP_MULTU, 32'd5, 32'd6, bc, ds, hk);
        n_cmp += 3;
        if (bc !== 32)     begin n_err++; $display("FAIL post_reset_busy_cycles: got %0d want 32", bc); end
        if (lo !== 32'd30) begin n_err++; $display("FAIL post_reset_lo: got %h want 0000001e", lo); end
        if (hi !== 32'd0)  begin n_err++; $display("FAIL post_reset_hi: got %h want 0", hi); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_mthi_mtlo;
        test_mult;
        test_multu;
        test_div;
        test_div_edge;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
